// File: rtl/audioqsys_pio_pkg.sv
// ----------------------------------------------------------------------------
// audioqsys_pio_pkg
//   Definitions shared by the audioqsys PIO slaves: the Avalon word-address
//   map, the slave data width, the read latency, and a helper that sizes the
//   debounce counters.
// ----------------------------------------------------------------------------
package audioqsys_pio_pkg;

    // Word addresses inside the PIO slave.
    typedef enum logic [1:0] {
        PIO_ADDR_DATA    = 2'd0,
        PIO_ADDR_RSVD    = 2'd1,
        PIO_ADDR_IRQMASK = 2'd2,
        PIO_ADDR_EDGE    = 2'd3
    } pio_addr_e;

    // readdata is registered, so it is valid one cycle after the read strobe.
    localparam int unsigned PIO_READ_LATENCY = 1;

    // Width of the Avalon data bus.
    localparam int unsigned PIO_DATA_W = 32;

    // The counter must be able to hold 0..cycles.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/audioqsys_debounce_bit.sv
// ----------------------------------------------------------------------------
// audioqsys_debounce_bit
//   Conditions one asynchronous input line. The line passes through a
//   two-flop synchroniser. The filtered level then follows the synchronised
//   value only after that value has differed from it for DEBOUNCE_CYCLES
//   consecutive clocks. If the line returns to the filtered level before
//   then, the count restarts.
//
//   Ports
//     clk    system clock
//     reset  synchronous, active-high reset
//     din    asynchronous input line
//     level  debounced (filtered) level
//     rise   one-cycle pulse, high in the cycle whose clock edge takes
//            level from 0 to 1
// ----------------------------------------------------------------------------
module audioqsys_debounce_bit
    import audioqsys_pio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int unsigned     CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          filt;
    logic [CW-1:0] cnt;
    logic          accept;

    // The change is accepted on the edge that would otherwise count the
    // DEBOUNCE_CYCLES-th consecutive mismatch.
    assign accept = (sync2 != filt) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            filt  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync2 == filt) begin
                cnt <= '0;
            end else if (accept) begin
                filt <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign level = filt;
    // rise is decoded from the accept condition, not from the registered
    // level. This lets the edge capture flop set on the same clock edge as
    // filt itself.
    assign rise  = accept && sync2;

endmodule

// File: rtl/audioqsys_headbang_sense_pio.sv
// ----------------------------------------------------------------------------
// audioqsys_headbang_sense_pio
//   Avalon-MM input PIO for the headbang system. It debounces WIDTH sensor
//   and button lines and exposes them to the CPU through four registers:
//     0 DATA        debounced levels (read only)
//     1 reserved    reads 0, writes ignored
//     2 IRQMASK     per-line interrupt enable
//     3 EDGECAPTURE latched rising edges, write 1 to clear a bit
//   irq is high while any captured edge has its mask bit set.
//
//   Ports
//     clk, reset         system clock, synchronous active-high reset
//     address            word address within the slave
//     chipselect         slave select
//     read_n, write_n    active-low read and write strobes
//     writedata          32-bit write data
//     readdata           32-bit read data, registered (latency 1)
//     irq                level interrupt to the CPU
//     in_port            WIDTH asynchronous external lines
// ----------------------------------------------------------------------------
module audioqsys_headbang_sense_pio
    import audioqsys_pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  read_n,
    input  logic                  write_n,
    input  logic [PIO_DATA_W-1:0] writedata,
    output logic [PIO_DATA_W-1:0] readdata,
    output logic                  irq,
    input  logic [WIDTH-1:0]      in_port
);

    logic [WIDTH-1:0]      filt;
    logic [WIDTH-1:0]      rise;
    logic [WIDTH-1:0]      edge_cap;
    logic [WIDTH-1:0]      edge_clr;
    logic [WIDTH-1:0]      irqmask;
    logic [PIO_DATA_W-1:0] rd_mux;
    logic                  wr_en;
    logic                  rd_en;
    pio_addr_e             addr;
    logic                  unused_wdata;

    // Only writedata[WIDTH-1:0] is stored. The upper bits are reduced here
    // so that they do not appear as dangling inputs.
    assign unused_wdata = ^writedata;

    // One debouncer per input line.
    for (genvar i = 0; i < WIDTH; i++) begin : g_line
        audioqsys_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .din   (in_port[i]),
            .level (filt[i]),
            .rise  (rise[i])
        );
    end

    assign addr  = pio_addr_e'(address);
    assign wr_en = chipselect && !write_n;
    assign rd_en = chipselect && !read_n;

    always_comb begin
        edge_clr = '0;
        if (wr_en && (addr == PIO_ADDR_EDGE)) begin
            edge_clr = writedata[WIDTH-1:0];
        end
    end

    // Read mux over the current register contents. A read issued in the same
    // cycle as a clear therefore returns the value before the clear.
    always_comb begin
        rd_mux = '0;
        unique case (addr)
            PIO_ADDR_DATA:    rd_mux[WIDTH-1:0] = filt;
            PIO_ADDR_RSVD:    rd_mux            = '0;
            PIO_ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
            PIO_ADDR_EDGE:    rd_mux[WIDTH-1:0] = edge_cap;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            edge_cap <= '0;
            irqmask  <= '0;
            readdata <= '0;
        end else begin
            // The set term is ORed in after the clear, so a new edge wins
            // over a clear of the same bit in the same cycle.
            edge_cap <= (edge_cap & ~edge_clr) | rise;
            if (wr_en && (addr == PIO_ADDR_IRQMASK)) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            if (rd_en) begin
                readdata <= rd_mux;
            end
        end
    end

    assign irq = |(edge_cap & irqmask);

endmodule

// File: tb/tb_audioqsys_headbang_sense_pio.sv
module tb_audioqsys_headbang_sense_pio;

    localparam int unsigned W  = 4;
    localparam int          D  = 16;
    localparam int          HN = 8192;

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic [1:0]    address    = 2'd0;
    logic          chipselect = 1'b0;
    logic          read_n     = 1'b1;
    logic          write_n    = 1'b1;
    logic [31:0]   writedata  = 32'd0;
    logic [31:0]   readdata;
    logic          irq;
    logic [W-1:0]  in_port    = '0;

    audioqsys_headbang_sense_pio #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .in_port    (in_port)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model.
    // hist[k] is the in_port value sampled at clock edge k. A line's
    // filtered level flips at edge n when the D samples taken at edges
    // n-D-1 .. n-2 all differ from the current level. The two-edge offset
    // accounts for the synchroniser. Samples taken at or before the most
    // recent reset edge count as 0.
    logic [W-1:0] hist [HN];
    int           n        = 0;
    int           last_rst = 0;
    logic [W-1:0] filt_m   = '0;
    logic [W-1:0] edge_m   = '0;
    logic [W-1:0] mask_m   = '0;
    logic [31:0]  rd_m     = '0;
    logic         irq_m    = 1'b0;

    function automatic logic sample(input int k, input int b);
        if (k <= last_rst) return 1'b0;
        return hist[k][b];
    endfunction

    function automatic logic window_differs(input int b);
        for (int k = n - D - 1; k <= n - 2; k++) begin
            if (sample(k, b) == filt_m[b]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [31:0] reg_val(input logic [1:0] a);
        logic [31:0] v;
        v = '0;
        case (a)
            2'd0:    v[W-1:0] = filt_m;
            2'd2:    v[W-1:0] = mask_m;
            2'd3:    v[W-1:0] = edge_m;
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic model_edge();
        logic [W-1:0] nf;
        logic [W-1:0] rise;
        logic [W-1:0] clr;
        logic         rd;
        logic         wr;
        n++;
        hist[n] = in_port;
        if (reset) begin
            last_rst = n;
            filt_m   = '0;
            edge_m   = '0;
            mask_m   = '0;
            rd_m     = '0;
        end else begin
            rd = chipselect && !read_n;
            wr = chipselect && !write_n;
            if (rd) rd_m = reg_val(address);
            nf = filt_m;
            for (int b = 0; b < int'(W); b++) begin
                if (window_differs(b)) nf[b] = ~filt_m[b];
            end
            rise   = nf & ~filt_m;
            clr    = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
            edge_m = (edge_m & ~clr) | rise;
            if (wr && address == 2'd2) mask_m = writedata[W-1:0];
            filt_m = nf;
        end
        irq_m = |(edge_m & mask_m);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("irq", {31'd0, irq}, {31'd0, irq_m});
        check("readdata", readdata, rd_m);
    endtask

    task automatic idle(input int c);
        repeat (c) tick();
    endtask

    task automatic bus_read(input logic [1:0] a);
        chipselect = 1'b1;
        read_n     = 1'b0;
        address    = a;
        tick();
        chipselect = 1'b0;
        read_n     = 1'b1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        int          r;
        logic [1:0]  a;

        // Reset values.
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 2'(i);
            bus_read(a);
            check("reset_read", readdata, 32'h0);
        end
        check("reset_irq", {31'd0, irq}, 32'h0);

        // Glitch rejection: 15 cycles high is one short of acceptance.
        in_port = 4'b0001;
        idle(15);
        in_port = 4'b0000;
        idle(25);
        bus_read(2'd0);
        check("glitch_data", readdata, 32'h0);
        bus_read(2'd3);
        check("glitch_edge", readdata, 32'h0);

        // Exact acceptance: filt changes at edge 18 after in_port changes.
        in_port = 4'b0101;
        idle(16);
        bus_read(2'd0);                       // edge 17 returns filt after edge 16
        check("accept_e17", readdata, 32'h0);
        bus_read(2'd0);                       // edge 18 returns filt after edge 17
        check("accept_e18", readdata, 32'h0);
        bus_read(2'd0);                       // edge 19 returns filt after edge 18
        check("accept_e19", readdata, 32'h5);
        bus_read(2'd3);
        check("accept_edge", readdata, 32'h5);

        // Mask, IRQ and write-1-to-clear.
        bus_write(2'd2, 32'h4);
        check("irq_masked_on", {31'd0, irq}, 32'h1);
        bus_write(2'd3, 32'h4);
        check("irq_cleared", {31'd0, irq}, 32'h0);
        bus_read(2'd3);
        check("w1c_edge", readdata, 32'h1);

        // Set wins: the clear of bit 1 lands on the edge where filt[1] rises.
        in_port = 4'b0111;
        idle(17);
        bus_write(2'd3, 32'h2);
        bus_read(2'd3);
        check("set_wins", readdata, 32'h3);

        // Reset at count 10 of a pending change, then a full re-acceptance.
        in_port = 4'b1111;
        idle(12);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle(16);
        bus_read(2'd0);
        check("rst_mid_e17", readdata, 32'h0);
        bus_read(2'd0);
        check("rst_mid_e18", readdata, 32'h0);
        bus_read(2'd0);
        check("rst_mid_e19", readdata, 32'hF);
        bus_read(2'd3);
        check("rst_mid_edge", readdata, 32'hF);

        // Reserved address and DATA writes are ignored.
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_read(2'd1);
        check("rsvd_read", readdata, 32'h0);
        bus_write(2'd0, 32'h0);
        bus_read(2'd0);
        check("data_ro", readdata, 32'hF);
        bus_read(2'd2);
        check("mask_after_rst", readdata, 32'h0);

        // Randomised traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 19) == 0) in_port = W'($urandom);
            r = int'($urandom_range(0, 99));
            a = 2'($urandom_range(0, 3));
            if (r < 35) begin
                bus_read(a);
            end else if (r < 50) begin
                bus_write(a, $urandom);
            end else if (r == 99) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
